// File: rtl/calendar_date_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calendar_date_counter_pkg
// Description : Calendar tables and helpers shared by the date counter:
//               calendar mode, FSM encoding, month lengths and cumulative
//               day offsets for the Gregorian and Symmetry010 calendars.
// Revision    : 1.0 - initial sequential date counter release
// ============================================================================
package calendar_date_counter_pkg;

    typedef enum logic [0:0] {CAL_GREG = 1'b0, CAL_SYM = 1'b1} cal_mode_t;

    typedef enum logic [0:0] {RUN = 1'b0, CHECK = 1'b1} fsm_t;

    // Common-year month lengths, January first
    localparam logic [5:0] MLEN_G [12] = '{6'd31, 6'd28, 6'd31, 6'd30, 6'd31, 6'd30,
                                           6'd31, 6'd31, 6'd30, 6'd31, 6'd30, 6'd31};
    localparam logic [5:0] MLEN_S [12] = '{6'd30, 6'd31, 6'd30, 6'd30, 6'd31, 6'd30,
                                           6'd30, 6'd31, 6'd30, 6'd30, 6'd31, 6'd30};

    // Days elapsed before the first of each month (common year)
    localparam logic [8:0] CUM_G [12] = '{9'd0,   9'd31,  9'd59,  9'd90,  9'd120, 9'd151,
                                          9'd181, 9'd212, 9'd243, 9'd273, 9'd304, 9'd334};
    localparam logic [8:0] CUM_S [12] = '{9'd0,   9'd30,  9'd61,  9'd91,  9'd121, 9'd152,
                                          9'd182, 9'd212, 9'd243, 9'd273, 9'd303, 9'd334};

    // Length of a month; December comes from the leap checker so the leap
    // week is handled in one place. Invalid months report length 0.
    function automatic logic [5:0] month_len(input cal_mode_t mode,
                                             input logic [3:0] mon,
                                             input logic       leap,
                                             input logic [5:0] dec_len);
        logic [5:0] len;
        len = 6'd0;
        if (mon >= 4'd1 && mon <= 4'd11) begin
            len = (mode == CAL_SYM) ? MLEN_S[mon - 4'd1] : MLEN_G[mon - 4'd1];
            if (mode == CAL_GREG && mon == 4'd2 && leap) begin
                len = 6'd29;
            end
        end else if (mon == 4'd12) begin
            len = dec_len;
        end
        return len;
    endfunction

    // Days before the first of the given month; invalid months give 0
    function automatic logic [8:0] cum_days(input cal_mode_t mode,
                                            input logic [3:0] mon);
        logic [8:0] cum;
        cum = 9'd0;
        if (mon >= 4'd1 && mon <= 4'd12) begin
            cum = (mode == CAL_SYM) ? CUM_S[mon - 4'd1] : CUM_G[mon - 4'd1];
        end
        return cum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calendar_date_counter_leap.sv
`default_nettype none
// ============================================================================
// Module      : calendar_leap_chk
// Description : Combinational leap-year check and December length for the
//               selected calendar. Symmetry010 leap week is enabled by the
//               SYM_LEAP_WEEK_EN macro; otherwise Symmetry years never leap.
// Revision    : 1.0 - initial sequential date counter release
// ============================================================================
module calendar_leap_chk #(
    parameter int CALENDAR = 0,
    parameter int YEAR_W   = 11
) (
    input  logic [YEAR_W-1:0] year,
    output logic              is_leap,
    output logic [5:0]        dec_len
);

    // Wide enough to hold 52*y+146 without overflow
    localparam int c_EW = YEAR_W + 7;

    logic [c_EW-1:0] w_year_ext;
    assign w_year_ext = {7'd0, year};

    generate
        if (CALENDAR == 0) begin : g_greg
            localparam logic [c_EW-1:0] c_D100 = c_EW'(100);
            localparam logic [c_EW-1:0] c_D400 = c_EW'(400);
            logic [c_EW-1:0] w_rem100;
            logic [c_EW-1:0] w_rem400;
            assign w_rem100 = w_year_ext % c_D100;
            assign w_rem400 = w_year_ext % c_D400;
            assign is_leap  = ((year[1:0] == 2'b00) && (w_rem100 != '0)) || (w_rem400 == '0);
            assign dec_len  = 6'd31;
        end else if (CALENDAR == 1) begin : g_sym
`ifdef SYM_LEAP_WEEK_EN
            localparam logic [c_EW-1:0] c_K52  = c_EW'(52);
            localparam logic [c_EW-1:0] c_K146 = c_EW'(146);
            localparam logic [c_EW-1:0] c_K293 = c_EW'(293);
            logic [c_EW-1:0] w_term;
            assign w_term  = (w_year_ext * c_K52 + c_K146) % c_K293;
            assign is_leap = (w_term < c_K52);
            assign dec_len = is_leap ? 6'd37 : 6'd30;
`else
            logic w_unused_year;
            assign w_unused_year = ^w_year_ext;
            assign is_leap = 1'b0;
            assign dec_len = 6'd30;
`endif
        end else begin : g_bad_cal
            $error("calendar_leap_chk: CALENDAR must be 0 or 1");
            logic w_unused_year;
            assign w_unused_year = ^w_year_ext;
            assign is_leap = 1'b0;
            assign dec_len = 6'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/calendar_date_counter.sv
`default_nettype none
// ============================================================================
// Module      : calendar_date_counter
// Description : Holds the current date and day-of-year, advances one day per
//               tick and accepts validated date loads through a two-state
//               RUN/CHECK handshake. Optional macro SYM_LEAP_WEEK_EN enables
//               the Symmetry010 leap week (CALENDAR=1 only).
// Revision    : 1.0 - initial sequential date counter release
// ============================================================================
module calendar_date_counter
    import calendar_date_counter_pkg::*;
#(
    parameter int CALENDAR   = 0,
    parameter int YEAR_W     = 11,
    parameter int RESET_YEAR = 2018
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [5:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    output logic [5:0]        dayOfMonth,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [8:0]        dayOfYear,
    output logic              year_wrap,
    output logic              load_err,
    output logic              tick_drop
);

    localparam cal_mode_t         c_MODE     = (CALENDAR == 1) ? CAL_SYM : CAL_GREG;
    localparam logic [0:0]        c_ST_RUN   = RUN;
    localparam logic [0:0]        c_ST_CHECK = CHECK;
    localparam logic [YEAR_W-1:0] c_YEAR_ONE = YEAR_W'(1);

    generate
        if (RESET_YEAR < 0 || RESET_YEAR >= (1 << YEAR_W)) begin : g_bad_reset_year
            $error("calendar_date_counter: RESET_YEAR does not fit in YEAR_W bits");
        end
    endgenerate

    logic [0:0]        r_state;
    logic [5:0]        r_day;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic [8:0]        r_doy;
    logic [5:0]        r_hold_day;
    logic [3:0]        r_hold_month;
    logic [YEAR_W-1:0] r_hold_year;
    logic              r_year_wrap;
    logic              r_load_err;
    logic              r_tick_drop;

    logic              w_cur_leap;
    logic [5:0]        w_cur_dec_len;
    logic              w_hold_leap;
    logic [5:0]        w_hold_dec_len;
    logic [5:0]        w_cur_len;
    logic [5:0]        w_hold_len;
    logic              w_hold_ok;
    logic              w_hold_leap_adj;
    logic [8:0]        w_hold_doy;
    logic              w_load_fire;

    calendar_leap_chk #(.CALENDAR(CALENDAR), .YEAR_W(YEAR_W)) u_leap_cur (
        .year    (r_year),
        .is_leap (w_cur_leap),
        .dec_len (w_cur_dec_len)
    );

    calendar_leap_chk #(.CALENDAR(CALENDAR), .YEAR_W(YEAR_W)) u_leap_hold (
        .year    (r_hold_year),
        .is_leap (w_hold_leap),
        .dec_len (w_hold_dec_len)
    );

    assign w_cur_len       = month_len(c_MODE, r_month, w_cur_leap, w_cur_dec_len);
    assign w_hold_len      = month_len(c_MODE, r_hold_month, w_hold_leap, w_hold_dec_len);
    assign w_hold_ok       = (r_hold_month >= 4'd1) && (r_hold_month <= 4'd12) &&
                             (r_hold_day != 6'd0) && (r_hold_day <= w_hold_len);
    // Gregorian leap day shifts every date after February by one
    assign w_hold_leap_adj = (c_MODE == CAL_GREG) && w_hold_leap && (r_hold_month > 4'd2);
    assign w_hold_doy      = cum_days(c_MODE, r_hold_month) + {3'd0, r_hold_day} +
                             {8'd0, w_hold_leap_adj};
    assign load_ready      = (r_state == c_ST_RUN);
    assign w_load_fire     = load_valid && load_ready;

    assign dayOfMonth = r_day;
    assign month      = r_month;
    assign year       = r_year;
    assign dayOfYear  = r_doy;
    assign year_wrap  = r_year_wrap;
    assign load_err   = r_load_err;
    assign tick_drop  = r_tick_drop;

    // Date advance, load capture/validation and status pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= c_ST_RUN;
            r_day        <= 6'd1;
            r_month      <= 4'd1;
            r_year       <= YEAR_W'(RESET_YEAR);
            r_doy        <= 9'd1;
            r_hold_day   <= 6'd0;
            r_hold_month <= 4'd0;
            r_hold_year  <= '0;
            r_year_wrap  <= 1'b0;
            r_load_err   <= 1'b0;
            r_tick_drop  <= 1'b0;
        end else begin
            r_year_wrap <= 1'b0;
            r_load_err  <= 1'b0;
            r_tick_drop <= 1'b0;
            if (r_state == c_ST_RUN) begin
                // A tick in the handshake cycle still advances the old date;
                // the validated load overwrites it one cycle later.
                if (tick) begin
                    if (r_day < w_cur_len) begin
                        r_day <= r_day + 6'd1;
                        r_doy <= r_doy + 9'd1;
                    end else if (r_month != 4'd12) begin
                        r_day   <= 6'd1;
                        r_month <= r_month + 4'd1;
                        r_doy   <= r_doy + 9'd1;
                    end else begin
                        r_day       <= 6'd1;
                        r_month     <= 4'd1;
                        r_doy       <= 9'd1;
                        r_year      <= r_year + c_YEAR_ONE;
                        r_year_wrap <= &r_year;
                    end
                end
                if (w_load_fire) begin
                    r_hold_day   <= load_day;
                    r_hold_month <= load_month;
                    r_hold_year  <= load_year;
                    r_state      <= c_ST_CHECK;
                end
            end else begin
                if (tick) begin
                    r_tick_drop <= 1'b1;
                end
                if (w_hold_ok) begin
                    r_day   <= r_hold_day;
                    r_month <= r_hold_month;
                    r_year  <= r_hold_year;
                    r_doy   <= w_hold_doy;
                end else begin
                    r_load_err <= 1'b1;
                end
                r_state <= c_ST_RUN;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calendar_date_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_calendar_date_counter
// Description : Scoreboard bench driving a Gregorian and a Symmetry010
//               instance with shared stimulus, checked against a calendar
//               model that derives day-of-year from first principles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calendar_date_counter;

    localparam int YEAR_W     = 11;
    localparam int RESET_YEAR = 2018;
    localparam int YMAX       = (1 << YEAR_W) - 1;

    typedef struct {
        int d;
        int m;
        int y;
        int doy;
        bit wrap;
        bit err;
        bit drop;
        bit ready;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic              tick = 1'b0;
    logic              load_valid = 1'b0;
    logic [5:0]        load_day = '0;
    logic [3:0]        load_month = '0;
    logic [YEAR_W-1:0] load_year = '0;

    logic              rdy0, rdy1, wrap0, wrap1, err0, err1, drop0, drop1;
    logic [5:0]        dom0, dom1;
    logic [3:0]        mon0, mon1;
    logic [YEAR_W-1:0] yr0, yr1;
    logic [8:0]        doy0, doy1;

    calendar_date_counter #(.CALENDAR(0), .YEAR_W(YEAR_W), .RESET_YEAR(RESET_YEAR)) u_greg (
        .clk(clk), .reset_n(reset_n), .tick(tick), .load_valid(load_valid),
        .load_ready(rdy0), .load_day(load_day), .load_month(load_month),
        .load_year(load_year), .dayOfMonth(dom0), .month(mon0), .year(yr0),
        .dayOfYear(doy0), .year_wrap(wrap0), .load_err(err0), .tick_drop(drop0)
    );

    calendar_date_counter #(.CALENDAR(1), .YEAR_W(YEAR_W), .RESET_YEAR(RESET_YEAR)) u_sym (
        .clk(clk), .reset_n(reset_n), .tick(tick), .load_valid(load_valid),
        .load_ready(rdy1), .load_day(load_day), .load_month(load_month),
        .load_year(load_year), .dayOfMonth(dom1), .month(mon1), .year(yr1),
        .dayOfYear(doy1), .year_wrap(wrap1), .load_err(err1), .tick_drop(drop1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    rec_t q0[$];
    rec_t q1[$];

    // ---------------- reference model ----------------
    int md[2], mm[2], my[2], hd[2], hm[2], hy[2];
    bit mchk[2];

    function automatic bit greg_leap(int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic bit sym_leap(int y);
`ifdef SYM_LEAP_WEEK_EN
        return ((52 * y + 146) % 293) < 52;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mlen(int c, int m, int y);
        if (m < 1 || m > 12) return 0;
        if (c == 0) begin
            if (m == 2) return greg_leap(y) ? 29 : 28;
            if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
            return 31;
        end
        if (m == 12) return sym_leap(y) ? 37 : 30;
        return (m % 3 == 2) ? 31 : 30;
    endfunction

    function automatic int doy_of(int c, int d, int m, int y);
        int s;
        s = d;
        for (int k = 1; k < m; k++) s += mlen(c, k, y);
        return s;
    endfunction

    task automatic model_step(input int c, output rec_t r);
        r.wrap = 1'b0;
        r.err  = 1'b0;
        r.drop = 1'b0;
        if (!reset_n) begin
            md[c] = 1; mm[c] = 1; my[c] = RESET_YEAR; mchk[c] = 1'b0;
        end else if (!mchk[c]) begin
            if (tick) begin
                if (md[c] < mlen(c, mm[c], my[c])) begin
                    md[c]++;
                end else begin
                    md[c] = 1;
                    if (mm[c] < 12) begin
                        mm[c]++;
                    end else begin
                        mm[c] = 1;
                        if (my[c] == YMAX) begin
                            my[c] = 0;
                            r.wrap = 1'b1;
                        end else begin
                            my[c]++;
                        end
                    end
                end
            end
            if (load_valid) begin
                hd[c] = int'(load_day);
                hm[c] = int'(load_month);
                hy[c] = int'(load_year);
                mchk[c] = 1'b1;
            end
        end else begin
            if (tick) r.drop = 1'b1;
            if (hm[c] >= 1 && hm[c] <= 12 && hd[c] >= 1 && hd[c] <= mlen(c, hm[c], hy[c])) begin
                md[c] = hd[c]; mm[c] = hm[c]; my[c] = hy[c];
            end else begin
                r.err = 1'b1;
            end
            mchk[c] = 1'b0;
        end
        r.d     = md[c];
        r.m     = mm[c];
        r.y     = my[c];
        r.doy   = doy_of(c, md[c], mm[c], my[c]);
        r.ready = !mchk[c];
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit rn, input bit tk, input bit lv,
                         input int d, input int m, input int y);
        rec_t r;
        @(negedge clk);
        #1;
        reset_n    = rn;
        tick       = tk;
        load_valid = lv;
        load_day   = 6'(d);
        load_month = 4'(m);
        load_year  = YEAR_W'(y);
        model_step(0, r);
        q0.push_back(r);
        model_step(1, r);
        q1.push_back(r);
    endtask

    task automatic load_date(input int d, input int m, input int y);
        drive(1'b1, 1'b0, 1'b1, d, m, y);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    task automatic compare(input string name, input rec_t e, input rec_t a);
        checks++;
        if (e.d != a.d || e.m != a.m || e.y != a.y || e.doy != a.doy ||
            e.wrap != a.wrap || e.err != a.err || e.drop != a.drop || e.ready != a.ready) begin
            errors++;
            $display("FAIL %s cyc=%0d got d=%0d m=%0d y=%0d doy=%0d wrap=%0d err=%0d drop=%0d rdy=%0d exp d=%0d m=%0d y=%0d doy=%0d wrap=%0d err=%0d drop=%0d rdy=%0d",
                     name, cyc, a.d, a.m, a.y, a.doy, a.wrap, a.err, a.drop, a.ready,
                     e.d, e.m, e.y, e.doy, e.wrap, e.err, e.drop, e.ready);
        end
    endtask

    always @(negedge clk) begin : mon
        rec_t e;
        rec_t a;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a.d = int'(dom0); a.m = int'(mon0); a.y = int'(yr0); a.doy = int'(doy0);
            a.wrap = wrap0; a.err = err0; a.drop = drop0; a.ready = rdy0;
            compare("greg", e, a);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a.d = int'(dom1); a.m = int'(mon1); a.y = int'(yr1); a.doy = int'(doy1);
            a.wrap = wrap1; a.err = err1; a.drop = drop1; a.ready = rdy1;
            compare("sym", e, a);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 5, 5, 5);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);

        // Leap February then March
        load_date(28, 2, 2016);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        // Century non-leap
        load_date(28, 2, 2100);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        // Year wrap at the top of the range
        load_date(31, 12, YMAX);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        load_date(30, 12, YMAX);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        // Invalid day with tick held through CHECK
        drive(1'b1, 1'b0, 1'b1, 31, 4, 2018);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        // Bad months and day zero
        load_date(10, 0, 2018);
        load_date(10, 13, 2018);
        load_date(0, 5, 2018);
        // Symmetry leap week
        load_date(30, 12, 2015);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        load_date(37, 12, 2015);
        drive(1'b1, 1'b1, 1'b0, 0, 0, 0);
        // Tick and handshake in the same cycle
        load_date(31, 1, 2020);
        drive(1'b1, 1'b1, 1'b1, 10, 7, 2021);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        // Reset during CHECK discards the load
        drive(1'b1, 1'b0, 1'b1, 15, 6, 2000);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int ysel;
            int y;
            ysel = int'($urandom_range(0, 3));
            if (ysel == 0)      y = int'($urandom_range(0, YMAX));
            else if (ysel == 1) y = YMAX - int'($urandom_range(0, 1));
            else                y = int'($urandom_range(1995, 2105));
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 39)), int'($urandom_range(0, 13)), y);
        end

        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got q0=%0d q1=%0d exp 0 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
